pc_gen: RTL

//  Program-counter generator directly upstream of fetch; drives the fetch PC input every cycle.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen_if.sv | 29 ++
 rtl/pc_redirect_buf.sv | 26 ++
 rtl/pc_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

  localparam int PC_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Only the two low address bits decide instruction alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control and status bundle between the pipeline front end and pc_gen.
interface pc_gen_if #(
  parameter int CNT_W = 32
);
  import pc_gen_pkg::*;

  logic             stall_i;
  logic             redirect_valid_i;
  logic [PC_W-1:0]  redirect_target_i;
  logic             trap_i;
  logic             halt_i;
  logic [PC_W-1:0]  pc_o;
  logic [PC_W-1:0]  pc_plus4_o;
  logic             pc_valid_o;
  logic             misaligned_o;
  logic [PC_W-1:0]  misaligned_addr_o;
  logic [CNT_W-1:0] retired_cnt_o;

  modport master (
    output stall_i, redirect_valid_i, redirect_target_i, trap_i, halt_i,
    input  pc_o, pc_plus4_o, pc_valid_o, misaligned_o, misaligned_addr_o, retired_cnt_o
  );

  modport slave (
    input  stall_i, redirect_valid_i, redirect_target_i, trap_i, halt_i,
    output pc_o, pc_plus4_o, pc_valid_o, misaligned_o, misaligned_addr_o, retired_cnt_o
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while fetch was stalled; the newest capture wins.
module pc_redirect_buf
  import pc_gen_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic [PC_W-1:0] capture_tgt,
  input  logic            clear,
  output logic            pend_v,
  output logic [PC_W-1:0] pend_tgt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else if (capture) begin
      pend_v   <= 1'b1;
      pend_tgt <= capture_tgt;
    end else if (clear) begin
      pend_v   <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot sequencing, redirect/trap/halt priority,
// misaligned-target trapping and retired-instruction counting.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);

  localparam logic [1:0] ST_BOOT = 2'(BOOT);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_HALT = 2'(HALT);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  pick_tgt;
  logic             pick_v;
  logic             mis_evt;
  logic             mis_q;
  logic [PC_W-1:0]  mis_addr_q;
  logic [CNT_W-1:0] cnt;
  logic             pend_v;
  logic [PC_W-1:0]  pend_tgt;
  logic             running;
  logic             advance;
  logic             retire;
  logic             capture;

  assign running = (state == ST_RUN);
  assign advance = running && !bus.stall_i;
  assign retire  = advance && !bus.halt_i;
  assign capture = running && bus.stall_i && bus.redirect_valid_i;

  pc_redirect_buf u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .capture_tgt (bus.redirect_target_i),
    .clear       (advance),
    .pend_v      (pend_v),
    .pend_tgt    (pend_tgt)
  );

  // Next-PC priority: halt, trap, live redirect, buffered redirect, then sequential.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    pick_v     = 1'b0;
    pick_tgt   = '0;
    mis_evt    = 1'b0;
    case (state)
      ST_BOOT: next_state = ST_RUN;
      ST_RUN: begin
        if (!bus.stall_i) begin
          if (bus.halt_i) begin
            next_state = ST_HALT;
          end else if (bus.trap_i) begin
            next_pc = TRAP_VEC;
          end else if (bus.redirect_valid_i) begin
            pick_v   = 1'b1;
            pick_tgt = bus.redirect_target_i;
          end else if (pend_v) begin
            pick_v   = 1'b1;
            pick_tgt = pend_tgt;
          end else begin
            next_pc = pc + PC_W'(INSTR_BYTES);
          end
        end
      end
      default: next_state = state;
    endcase
    // A redirect target that is not word aligned diverts to the trap vector.
    if (pick_v) begin
      if (is_misaligned(pick_tgt[1:0])) begin
        next_pc = TRAP_VEC;
        mis_evt = 1'b1;
      end else begin
        next_pc = pick_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      cnt        <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      mis_q <= mis_evt;
      if (mis_evt) begin
        mis_addr_q <= pick_tgt;
      end
      if (retire) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_o              = pc;
  assign bus.pc_plus4_o        = pc + PC_W'(INSTR_BYTES);
  assign bus.pc_valid_o        = running;
  assign bus.misaligned_o      = mis_q;
  assign bus.misaligned_addr_o = mis_addr_q;
  assign bus.retired_cnt_o     = cnt;

endmodule
